trng_sequencer: RTL and testbench
=================================

# trng_sequencer

Bus initiator that drives the TRNG register-map slave port on the user's behalf. On a start pulse it programs the polynomial, seed and time-window maximum, then sets the request bit. It reads LFSR words at a programmable interval and delivers them on a valid/ready stream. When the requested word count is reached, or on abort, it clears the request bit and reports done.

## Interface
- ADDR_WIDTH, 13, slave byte-address width.
- LFSR_WIDTH, 32, LFSR/seed/polynomial width; upper bus bits beyond it are 0.
- TMW_WIDTH, 23, time-window maximum width.
- CNT_WIDTH, 16, width of num_words_i and interval_i.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle start pulse; ignored while busy_o=1.
- abort_i  in  1  one-cycle pulse; terminates a run.
- seed_i  in  LFSR_WIDTH  seed, latched at start.
- poly_i  in  LFSR_WIDTH  feedback polynomial, latched at start.
- tmw_max_i  in  TMW_WIDTH  time-window maximum, latched at start.
- interval_i  in  CNT_WIDTH  cycles between reads, latched at start; 0 is treated as 1.
- num_words_i  in  CNT_WIDTH  words to deliver, latched at start; 0 means run until abort.
- en_o  out  1  bus transaction enable.
- we_o  out  4  byte write strobes: 4'hF on writes, 0 on reads.
- addr_o  out  ADDR_WIDTH  byte address.
- wrdata_o  out  32  write data.
- rdata_i  in  32  read data, valid one cycle after the read cycle.
- rnd_data_o  out  LFSR_WIDTH  random word.
- rnd_valid_o  out  1  rnd_data_o valid.
- rnd_ready_i  in  1  consumer accepts.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse on return to IDLE.

## Operation
- Register addresses (index in addr[ADDR_WIDTH-1:4], low nibble 0):
  - request 0x010
  - LFSR 0x020
  - polynomial 0x030
  - TMW max 0x050
- States: IDLE, WR_POLY, WR_SEED, WR_TMW, WR_REQ_ON, WAIT, RD, RD_WAIT, OUT, WR_REQ_OFF, DONE.
- Each WR_*/RD state drives exactly one bus cycle (en_o=1). en_o=0 in all other states. All bus outputs are registered.
- IDLE: start_i latches all *_i configuration and sets busy_o=1. The configuration writes then run in the order WR_POLY, WR_SEED, WR_TMW, WR_REQ_ON (wrdata_o=1).
- WAIT: an interval counter loads max(interval_i,1) on entry and decrements each cycle. It moves to RD when the count reaches 1.
- RD: addr_o=0x020, we_o=0. RD_WAIT captures rdata_i[LFSR_WIDTH-1:0] into rnd_data_o and sets rnd_valid_o.
- OUT: holds rnd_data_o stable while rnd_valid_o=1 && rnd_ready_i=0. On the handshake:
  - clear valid and increment the word counter;
  - if num_words≠0 and count==num_words, go to WR_REQ_OFF;
  - else go to WAIT.
- WR_REQ_OFF: writes 0 to 0x010. DONE pulses done_o=1 and clears busy_o, then returns to IDLE.
- abort_i in any busy state except WR_REQ_OFF/DONE goes to WR_REQ_OFF on the next cycle. Any pending rnd_valid_o is dropped and that word is not counted.
- abort_i in IDLE has no effect. If start_i and abort_i arrive together in IDLE, start wins.
- The word counter saturates at all-ones when num_words=0 and does not terminate the run.

## Timing
- Reset values: en_o=0, we_o=0, addr_o=0, wrdata_o=0, rnd_data_o=0, rnd_valid_o=0, busy_o=0, done_o=0, state IDLE, counters 0.
- A reset mid-run returns immediately to IDLE. The shared rst also clears the slave request bit, so no off-write is issued.
- start_i is sampled at edge 0. Bus cycles follow:
  - edge 1: polynomial write
  - edge 2: seed write
  - edge 3: TMW write
  - edge 4: request write
- First read issues interval cycles after WR_REQ_ON. rnd_valid_o rises 2 cycles after the RD cycle begins.
- Throughput with ready held high: one word per interval+3 cycles.
- busy_o rises the cycle after start_i and falls together with the done_o pulse.

## Test plan
- poly=0x80200003, seed=0x1, tmw=0x100, interval=4, num_words=2, start -> writes appear at addr 0x030/0x020/0x050/0x010 with data poly/seed/0x100/1 on 4 consecutive cycles, we_o=4'hF, each with en_o=1.
- A slave model returns 0xDEADBEEF one cycle after the 0x020 read -> rnd_data_o=0xDEADBEEF with rnd_valid_o=1; 2 words delivered, then write 0 to 0x010 and done_o pulses once.
- Hold rnd_ready_i=0 for 10 cycles -> data stable, no new read issued; accepted on the first ready cycle.
- num_words=0 with ready high -> 20 words delivered; abort -> request-off write, done_o pulse, no further reads.
- Assert rst during WAIT -> all outputs 0 immediately; a subsequent start runs the full sequence again.
- start_i pulsed while busy_o=1, and interval=0 -> start ignored; reads issue every 4 cycles (interval treated as 1).

Source files
------------

// File: rtl/trng_sequencer.sv
// trng_sequencer: bus initiator that configures the TRNG slave, then
// periodically reads LFSR words and streams them out on valid/ready.
// The FSM state always names the bus cycle currently being presented,
// so every bus output is registered together with the state transition.
module trng_sequencer #(
  parameter int ADDR_WIDTH = 13,
  parameter int LFSR_WIDTH = 32,
  parameter int TMW_WIDTH  = 23,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [LFSR_WIDTH-1:0] seed_i,
  input  logic [LFSR_WIDTH-1:0] poly_i,
  input  logic [TMW_WIDTH-1:0]  tmw_max_i,
  input  logic [CNT_WIDTH-1:0]  interval_i,
  input  logic [CNT_WIDTH-1:0]  num_words_i,
  output logic                  en_o,
  output logic [3:0]            we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [31:0]           wrdata_o,
  input  logic [31:0]           rdata_i,
  output logic [LFSR_WIDTH-1:0] rnd_data_o,
  output logic                  rnd_valid_o,
  input  logic                  rnd_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_REQ  = ADDR_WIDTH'(12'h010);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LFSR = ADDR_WIDTH'(12'h020);
  localparam logic [ADDR_WIDTH-1:0] ADDR_POLY = ADDR_WIDTH'(12'h030);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TMW  = ADDR_WIDTH'(12'h050);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [3:0] {
    IDLE, WR_POLY, WR_SEED, WR_TMW, WR_REQ_ON, WAIT, RD, RD_WAIT, OUT,
    WR_REQ_OFF, DONE
  } state_t;

  state_t                state;
  logic [LFSR_WIDTH-1:0] seed_reg;
  logic [LFSR_WIDTH-1:0] poly_reg;
  logic [TMW_WIDTH-1:0]  tmw_reg;
  logic [CNT_WIDTH-1:0]  interval_reg;
  logic [CNT_WIDTH-1:0]  num_words_reg;
  logic [CNT_WIDTH-1:0]  wait_cnt_reg;
  logic [CNT_WIDTH-1:0]  word_cnt_reg;
  logic                  abortable;
  logic [CNT_WIDTH-1:0]  interval_eff;

  // Abort is honoured only while a run is active and before shutdown began.
  always_comb begin
    abortable = (state != IDLE) && (state != WR_REQ_OFF) && (state != DONE);
  end

  // An interval of zero behaves exactly like an interval of one.
  always_comb begin
    interval_eff = (interval_reg == '0) ? CNT_ONE : interval_reg;
  end

  // Main sequencer: state, bus outputs, stream outputs and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      en_o          <= 1'b0;
      we_o          <= 4'h0;
      addr_o        <= '0;
      wrdata_o      <= '0;
      rnd_data_o    <= '0;
      rnd_valid_o   <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      seed_reg      <= '0;
      poly_reg      <= '0;
      tmw_reg       <= '0;
      interval_reg  <= '0;
      num_words_reg <= '0;
      wait_cnt_reg  <= '0;
      word_cnt_reg  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            seed_reg      <= seed_i;
            poly_reg      <= poly_i;
            tmw_reg       <= tmw_max_i;
            interval_reg  <= interval_i;
            num_words_reg <= num_words_i;
            word_cnt_reg  <= '0;
            busy_o        <= 1'b1;
            en_o          <= 1'b1;
            we_o          <= 4'hF;
            addr_o        <= ADDR_POLY;
            wrdata_o      <= 32'(poly_i);
            state         <= WR_POLY;
          end
        end
        WR_POLY: begin
          addr_o   <= ADDR_LFSR;
          wrdata_o <= 32'(seed_reg);
          state    <= WR_SEED;
        end
        WR_SEED: begin
          addr_o   <= ADDR_TMW;
          wrdata_o <= 32'(tmw_reg);
          state    <= WR_TMW;
        end
        WR_TMW: begin
          addr_o   <= ADDR_REQ;
          wrdata_o <= 32'd1;
          state    <= WR_REQ_ON;
        end
        WR_REQ_ON: begin
          en_o         <= 1'b0;
          we_o         <= 4'h0;
          wait_cnt_reg <= interval_eff;
          state        <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_reg <= CNT_ONE) begin
            en_o   <= 1'b1;
            we_o   <= 4'h0;
            addr_o <= ADDR_LFSR;
            state  <= RD;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - CNT_ONE;
          end
        end
        RD: begin
          en_o  <= 1'b0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          rnd_data_o  <= rdata_i[LFSR_WIDTH-1:0];
          rnd_valid_o <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (rnd_ready_i) begin
            rnd_valid_o <= 1'b0;
            if (word_cnt_reg != '1) word_cnt_reg <= word_cnt_reg + CNT_ONE;
            if ((num_words_reg != '0) && ((word_cnt_reg + CNT_ONE) == num_words_reg)) begin
              en_o     <= 1'b1;
              we_o     <= 4'hF;
              addr_o   <= ADDR_REQ;
              wrdata_o <= 32'd0;
              state    <= WR_REQ_OFF;
            end else begin
              wait_cnt_reg <= interval_eff;
              state        <= WAIT;
            end
          end
        end
        WR_REQ_OFF: begin
          en_o   <= 1'b0;
          we_o   <= 4'h0;
          busy_o <= 1'b0;
          done_o <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Abort overrides whatever the case above chose: drop any pending
      // word (uncounted) and go straight to clearing the request bit.
      if (abort_i && abortable) begin
        rnd_valid_o <= 1'b0;
        en_o        <= 1'b1;
        we_o        <= 4'hF;
        addr_o      <= ADDR_REQ;
        wrdata_o    <= 32'd0;
        state       <= WR_REQ_OFF;
      end
    end
  end

endmodule

// File: tb/tb_trng_sequencer.sv
// Self-checking bench for trng_sequencer: a slave model answers LFSR reads,
// a monitor logs bus cycles and accepted words, and each test compares the
// logs with an expected bus schedule derived from the configuration.
module tb_trng_sequencer;

  localparam int AW = 13;
  localparam int LW = 32;
  localparam int TW = 23;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [LW-1:0] seed_i = '0;
  logic [LW-1:0] poly_i = '0;
  logic [TW-1:0] tmw_max_i = '0;
  logic [CW-1:0] interval_i = '0;
  logic [CW-1:0] num_words_i = '0;
  logic          en_o;
  logic [3:0]    we_o;
  logic [AW-1:0] addr_o;
  logic [31:0]   wrdata_o;
  logic [31:0]   rdata_i = '0;
  logic [LW-1:0] rnd_data_o;
  logic          rnd_valid_o;
  logic          rnd_ready_i = 1'b0;
  logic          busy_o;
  logic          done_o;

  trng_sequencer #(.ADDR_WIDTH(AW), .LFSR_WIDTH(LW), .TMW_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .seed_i(seed_i), .poly_i(poly_i), .tmw_max_i(tmw_max_i),
    .interval_i(interval_i), .num_words_i(num_words_i),
    .en_o(en_o), .we_o(we_o), .addr_o(addr_o), .wrdata_o(wrdata_o),
    .rdata_i(rdata_i), .rnd_data_o(rnd_data_o), .rnd_valid_o(rnd_valid_o),
    .rnd_ready_i(rnd_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [3:0]    we;
    logic [31:0]   data;
  } txn_t;

  txn_t        bus_q[$];
  txn_t        exp_bus[$];
  logic [31:0] exp_words[$];
  logic [31:0] got_words[$];
  int          done_cnt;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          ready_mode = 0;   // 0: ready high, 1: random, 2: ready low
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_word = 32'hDEADBEEF;
  logic [31:0] slave_w;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: answers an LFSR read one cycle later and records what it sent.
  always @(posedge clk) begin
    if (!rst && en_o && we_o == 4'h0 && addr_o == 13'h020) begin
      slave_w = use_fixed ? fixed_word : $urandom;
      rdata_i <= slave_w;
      exp_words.push_back(slave_w);
    end
  end

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (en_o) bus_q.push_back('{cyc: cyc, addr: addr_o, we: we_o, data: wrdata_o});
      if (rnd_valid_o && rnd_ready_i && !abort_i) got_words.push_back(rnd_data_o);
      if (done_o) done_cnt++;
    end
  end

  // Consumer ready driver.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       rnd_ready_i = 1'b1;
      1:       rnd_ready_i = 1'($urandom_range(0, 1));
      default: rnd_ready_i = 1'b0;
    endcase
  end

  function automatic void push_exp(input int c, input logic [AW-1:0] a, input logic [3:0] w,
                                   input logic [31:0] d);
    exp_bus.push_back('{cyc: c, addr: a, we: w, data: d});
  endfunction

  // Expected bus schedule when the consumer is always ready.
  function automatic void build_exp(input logic [31:0] poly, input logic [31:0] seed,
                                    input logic [TW-1:0] tmw, input int ival, input int n,
                                    input int s);
    int im;
    int r;
    int last;
    im = (ival == 0) ? 1 : ival;
    exp_bus.delete();
    push_exp(s,     13'h030, 4'hF, poly);
    push_exp(s + 1, 13'h020, 4'hF, seed);
    push_exp(s + 2, 13'h050, 4'hF, 32'(tmw));
    push_exp(s + 3, 13'h010, 4'hF, 32'd1);
    r = s + 4 + im;
    last = r;
    for (int k = 0; k < n; k++) begin
      push_exp(r, 13'h020, 4'h0, 32'd0);
      last = r;
      r = r + im + 3;
    end
    push_exp(last + 3, 13'h010, 4'hF, 32'd0);
  endfunction

  task automatic clear_mon();
    bus_q.delete();
    exp_words.delete();
    got_words.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [31:0] poly, input logic [31:0] seed,
                             input logic [TW-1:0] tmw, input int ival, input int n,
                             output int s);
    @(posedge clk); #1;
    poly_i = poly; seed_i = seed; tmw_max_i = tmw;
    interval_i = CW'(ival); num_words_i = CW'(n);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [95:0] outs;
    @(negedge clk);
    outs = {31'd0, en_o, we_o, addr_o, wrdata_o, rnd_valid_o, busy_o, done_o};
    checks++;
    if (outs !== 96'd0) begin
      failures++;
      $display("FAIL reset_ctrl got=%h want=0", outs);
    end
    checks++;
    if (rnd_data_o !== '0) begin
      failures++;
      $display("FAIL reset_rnd got=%h want=0", rnd_data_o);
    end
    @(posedge clk); #1 rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int s;
    bit ok;
    clear_mon();
    ready_mode = 0;
    use_fixed = 1'b1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_idle got=%b want=0", busy_o);
    end
    pulse_start(32'h80200003, 32'h1, 23'h100, 4, 2, s);
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_rise got=%b want=1", busy_o);
    end
    wait_done(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_timeout got=no_done want=done");
    end
    build_exp(32'h80200003, 32'h1, 23'h100, 4, 2, s);
    checks++;
    if (bus_q.size() != exp_bus.size()) begin
      failures++;
      $display("FAIL basic_ntxn got=%0d want=%0d", bus_q.size(), exp_bus.size());
    end
    for (int i = 0; i < exp_bus.size() && i < bus_q.size(); i++) begin
      checks++;
      if (bus_q[i].cyc != exp_bus[i].cyc || bus_q[i].addr !== exp_bus[i].addr ||
          bus_q[i].we !== exp_bus[i].we ||
          (exp_bus[i].we != 4'h0 && bus_q[i].data !== exp_bus[i].data)) begin
        failures++;
        $display("FAIL basic_txn%0d got=c%0d a%h w%h d%h want=c%0d a%h w%h d%h", i,
                 bus_q[i].cyc, bus_q[i].addr, bus_q[i].we, bus_q[i].data,
                 exp_bus[i].cyc, exp_bus[i].addr, exp_bus[i].we, exp_bus[i].data);
      end
    end
    checks++;
    if (got_words.size() != 2 || got_words[0] !== 32'hDEADBEEF || got_words[1] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_words got=%0d words want=2 x deadbeef", got_words.size());
    end
    checks++;
    if (done_cnt != 1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got=pulses%0d busy%b want=1 busy0", done_cnt, busy_o);
    end
    use_fixed = 1'b0;
    $display("test_basic txns=%0d words=%0d", bus_q.size(), got_words.size());
  endtask

  task automatic test_backpressure();
    int s;
    int nbus;
    int nacc;
    bit ok;
    bit seen;
    logic [31:0] held;
    clear_mon();
    ready_mode = 2;
    pulse_start($urandom, $urandom, 23'($urandom), 3, 2, s);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rnd_valid_o) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_valid_timeout got=no_valid want=valid");
    end
    held = rnd_data_o;
    nbus = bus_q.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rnd_valid_o !== 1'b1 || rnd_data_o !== held || bus_q.size() != nbus) begin
        failures++;
        $display("FAIL bp_hold%0d got=v%b d%h n%0d want=v1 d%h n%0d", i, rnd_valid_o,
                 rnd_data_o, bus_q.size(), held, nbus);
      end
    end
    nacc = got_words.size();
    ready_mode = 0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (got_words.size() != nacc + 1 || got_words[nacc] !== exp_words[0]) begin
      failures++;
      $display("FAIL bp_accept got=%0d want=%0d", got_words.size(), nacc + 1);
    end
    wait_done(200, ok);
    checks++;
    if (!ok || done_cnt != 1 || got_words.size() != 2) begin
      failures++;
      $display("FAIL bp_finish got=ok%b done%0d words%0d want=ok1 done1 words2", ok, done_cnt,
               got_words.size());
    end
    $display("test_backpressure words=%0d", got_words.size());
  endtask

  task automatic test_abort_unbounded();
    int s;
    int a_cyc;
    int late_reads;
    bit ok;
    bit prefix_ok;
    clear_mon();
    ready_mode = 0;
    pulse_start($urandom, $urandom, 23'($urandom), 2, 0, s);
    for (int i = 0; i < 400 && got_words.size() < 20; i++) @(negedge clk);
    checks++;
    if (got_words.size() < 20) begin
      failures++;
      $display("FAIL abort_words got=%0d want>=20", got_words.size());
    end
    repeat ($urandom_range(0, 4)) @(posedge clk);
    @(posedge clk); #1;
    abort_i = 1'b1;
    a_cyc = cyc;
    @(posedge clk); #1;
    abort_i = 1'b0;
    wait_done(50, ok);
    checks++;
    if (!ok || done_cnt != 1) begin
      failures++;
      $display("FAIL abort_done got=ok%b pulses%0d want=ok1 pulses1", ok, done_cnt);
    end
    checks++;
    if (bus_q.size() == 0 || bus_q[$].cyc != a_cyc + 1 || bus_q[$].addr !== 13'h010 ||
        bus_q[$].we !== 4'hF || bus_q[$].data !== 32'd0) begin
      failures++;
      $display("FAIL abort_offwrite got=c%0d a%h d%h want=c%0d a010 d0", bus_q[$].cyc,
               bus_q[$].addr, bus_q[$].data, a_cyc + 1);
    end
    late_reads = 0;
    foreach (bus_q[i]) if (bus_q[i].we == 4'h0 && bus_q[i].cyc > a_cyc) late_reads++;
    checks++;
    if (late_reads != 0) begin
      failures++;
      $display("FAIL abort_noreads got=%0d want=0", late_reads);
    end
    prefix_ok = (got_words.size() <= exp_words.size());
    for (int i = 0; i < got_words.size() && prefix_ok; i++)
      if (got_words[i] !== exp_words[i]) prefix_ok = 1'b0;
    checks++;
    if (!prefix_ok) begin
      failures++;
      $display("FAIL abort_data got=%0d words want=matching slave words", got_words.size());
    end
    $display("test_abort_unbounded words=%0d", got_words.size());
  endtask

  task automatic test_reset_mid();
    int s;
    bit ok;
    logic [127:0] outs;
    clear_mon();
    ready_mode = 0;
    pulse_start($urandom, $urandom, 23'($urandom), 10, 3, s);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    outs = {en_o, we_o, addr_o, wrdata_o, rnd_data_o, rnd_valid_o, busy_o, done_o, 45'd0};
    checks++;
    if (outs !== 128'd0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%h want=0", outs);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus_q.size() != 4 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_quiet got=%0d busy%b want=4 busy0", bus_q.size(), busy_o);
    end
    clear_mon();
    pulse_start(32'h1234ABCD, 32'h55, 23'h7F, 2, 3, s);
    wait_done(200, ok);
    build_exp(32'h1234ABCD, 32'h55, 23'h7F, 2, 3, s);
    checks++;
    if (!ok || bus_q.size() != exp_bus.size() || done_cnt != 1) begin
      failures++;
      $display("FAIL rstmid_rerun got=ok%b n%0d done%0d want=ok1 n%0d done1", ok, bus_q.size(),
               done_cnt, exp_bus.size());
    end
    for (int i = 0; i < exp_bus.size() && i < bus_q.size(); i++) begin
      checks++;
      if (bus_q[i].cyc != exp_bus[i].cyc || bus_q[i].addr !== exp_bus[i].addr ||
          (exp_bus[i].we != 4'h0 && bus_q[i].data !== exp_bus[i].data)) begin
        failures++;
        $display("FAIL rstmid_txn%0d got=c%0d a%h d%h want=c%0d a%h d%h", i, bus_q[i].cyc,
                 bus_q[i].addr, bus_q[i].data, exp_bus[i].cyc, exp_bus[i].addr, exp_bus[i].data);
      end
    end
    $display("test_reset_mid rerun_txns=%0d", bus_q.size());
  endtask

  task automatic test_start_busy_interval0();
    int s;
    bit ok;
    logic [31:0] poly;
    logic [31:0] seed;
    clear_mon();
    ready_mode = 0;
    poly = $urandom;
    seed = $urandom;
    pulse_start(poly, seed, 23'h3, 0, 5, s);
    repeat (6) @(posedge clk);
    #1 start_i = 1'b1;
    poly_i = ~poly;
    @(posedge clk); #1 start_i = 1'b0;
    wait_done(200, ok);
    build_exp(poly, seed, 23'h3, 0, 5, s);
    checks++;
    if (!ok || bus_q.size() != exp_bus.size() || done_cnt != 1) begin
      failures++;
      $display("FAIL busy_start_n got=ok%b n%0d done%0d want=ok1 n%0d done1", ok, bus_q.size(),
               done_cnt, exp_bus.size());
    end
    for (int i = 0; i < exp_bus.size() && i < bus_q.size(); i++) begin
      checks++;
      if (bus_q[i].cyc != exp_bus[i].cyc || bus_q[i].addr !== exp_bus[i].addr ||
          bus_q[i].we !== exp_bus[i].we ||
          (exp_bus[i].we != 4'h0 && bus_q[i].data !== exp_bus[i].data)) begin
        failures++;
        $display("FAIL busy_start_txn%0d got=c%0d a%h w%h want=c%0d a%h w%h", i, bus_q[i].cyc,
                 bus_q[i].addr, bus_q[i].we, exp_bus[i].cyc, exp_bus[i].addr, exp_bus[i].we);
      end
    end
    $display("test_start_busy_interval0 txns=%0d", bus_q.size());
  endtask

  task automatic test_random_runs();
    int s;
    int n;
    int ival;
    int im;
    int prev_rd;
    bit ok;
    bit seq_ok;
    logic [31:0] poly;
    logic [31:0] seed;
    logic [TW-1:0] tmw;
    for (int run = 0; run < 4; run++) begin
      clear_mon();
      ready_mode = 1;
      poly = $urandom; seed = $urandom; tmw = TW'($urandom);
      ival = $urandom_range(0, 5);
      n = $urandom_range(1, 6);
      im = (ival == 0) ? 1 : ival;
      pulse_start(poly, seed, tmw, ival, n, s);
      wait_done(1500, ok);
      build_exp(poly, seed, tmw, ival, n, s);
      seq_ok = ok && (bus_q.size() == exp_bus.size()) && (done_cnt == 1);
      prev_rd = -1000;
      for (int i = 0; i < exp_bus.size() && i < bus_q.size(); i++) begin
        if (bus_q[i].addr !== exp_bus[i].addr || bus_q[i].we !== exp_bus[i].we ||
            (exp_bus[i].we != 4'h0 && bus_q[i].data !== exp_bus[i].data)) seq_ok = 1'b0;
        if (i < 4 && bus_q[i].cyc != exp_bus[i].cyc) seq_ok = 1'b0;
        if (bus_q[i].we == 4'h0) begin
          if (bus_q[i].cyc - prev_rd < im + 3) seq_ok = 1'b0;
          prev_rd = bus_q[i].cyc;
        end
      end
      checks++;
      if (!seq_ok) begin
        failures++;
        $display("FAIL rand%0d_bus got=ok%b n%0d done%0d want=ok1 n%0d done1 (ival=%0d nw=%0d)",
                 run, ok, bus_q.size(), done_cnt, exp_bus.size(), ival, n);
      end
      checks++;
      if (got_words != exp_words || got_words.size() != n) begin
        failures++;
        $display("FAIL rand%0d_words got=%0d want=%0d matching slave words", run,
                 got_words.size(), n);
      end
      $display("test_random_runs run=%0d ival=%0d nw=%0d words=%0d", run, ival, n, got_words.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort_unbounded();
    test_reset_mid();
    test_start_busy_interval0();
    test_random_runs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
